bit_stream_monitor: RTL and testbench

Sequential monitor that sits directly downstream of the four-register inverter/gate pipeline and consumes its single-bit `out` stream. It tracks bit history, counts transitions, measures run lengths, flags stuck-at behaviour, and detects a programmable 4-bit pattern. Violating-path and functional benches use its outputs to confirm that the upstream netlist produces a live, correctly sequenced stream.

---
 rtl/bit_stream_monitor.sv | 142 ++++++++++++++
 tb/tb_bit_stream_monitor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_stream_monitor.sv
// Bit stream monitor: tracks the last 8 accepted bits, counts transitions and run
// lengths, flags stuck-at runs and detects a programmable 4-bit pattern.
module bit_stream_monitor #(
    parameter int         CNT_W   = 8,
    parameter logic [3:0] PATTERN = 4'b1011,
    parameter int         MAX_RUN = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             clear,
    output logic [7:0]       history,
    output logic [CNT_W-1:0] edge_count,
    output logic [CNT_W-1:0] run_len,
    output logic             stuck,
    output logic             stuck_val,
    output logic             match
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_RUN   = 2'd1,
        S_STUCK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MAX_RUN_C = CNT_W'(MAX_RUN);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    state_t           state_r;
    logic [7:0]       history_r;
    logic [CNT_W-1:0] edge_count_r;
    logic [CNT_W-1:0] run_len_r;
    logic             stuck_r;
    logic             stuck_val_r;
    logic             match_r;
    logic [2:0]       fill_r;

    logic [7:0]       hist_next_s;
    logic [2:0]       fill_next_s;
    logic [CNT_W-1:0] run_inc_s;
    logic [CNT_W-1:0] edge_inc_s;
    logic             same_s;
    logic             match_next_s;

    // Next-value terms used when a bit is accepted this cycle.
    always_comb begin
        hist_next_s  = {history_r[6:0], in_bit};
        run_inc_s    = sat_inc(run_len_r);
        edge_inc_s   = sat_inc(edge_count_r);
        same_s       = (in_bit == history_r[0]);
        if (fill_r == 3'd4) begin
            fill_next_s = 3'd4;
        end else begin
            fill_next_s = fill_r + 3'd1;
        end
        // Fill gating keeps pre-reset or zero-filled history from forming a match.
        match_next_s = (fill_next_s == 3'd4) && (hist_next_s[3:0] == PATTERN);
    end

    // Run-tracking FSM with all outputs registered; rst outranks clear, clear outranks data.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_r      <= S_EMPTY;
            history_r    <= 8'h00;
            edge_count_r <= CNT_ZERO;
            run_len_r    <= CNT_ZERO;
            stuck_r      <= 1'b0;
            stuck_val_r  <= 1'b0;
            match_r      <= 1'b0;
            fill_r       <= 3'd0;
        end else if (in_valid) begin
            history_r <= hist_next_s;
            fill_r    <= fill_next_s;
            match_r   <= match_next_s;
            case (state_r)
                S_EMPTY: begin
                    run_len_r <= CNT_ONE;
                    state_r   <= S_RUN;
                end
                S_RUN: begin
                    if (same_s) begin
                        run_len_r <= run_inc_s;
                        if (run_inc_s >= MAX_RUN_C) begin
                            state_r     <= S_STUCK;
                            stuck_r     <= 1'b1;
                            stuck_val_r <= in_bit;
                        end else begin
                            state_r <= S_RUN;
                        end
                    end else begin
                        edge_count_r <= edge_inc_s;
                        run_len_r    <= CNT_ONE;
                        state_r      <= S_RUN;
                        stuck_r      <= 1'b0;
                    end
                end
                S_STUCK: begin
                    if (same_s) begin
                        run_len_r <= run_inc_s;
                        state_r   <= S_STUCK;
                    end else begin
                        edge_count_r <= edge_inc_s;
                        run_len_r    <= CNT_ONE;
                        state_r      <= S_RUN;
                        stuck_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= S_EMPTY;
                    history_r    <= 8'h00;
                    edge_count_r <= CNT_ZERO;
                    run_len_r    <= CNT_ZERO;
                    stuck_r      <= 1'b0;
                    stuck_val_r  <= 1'b0;
                    match_r      <= 1'b0;
                    fill_r       <= 3'd0;
                end
            endcase
        end else begin
            match_r <= 1'b0;
        end
    end

    assign history    = history_r;
    assign edge_count = edge_count_r;
    assign run_len    = run_len_r;
    assign stuck      = stuck_r;
    assign stuck_val  = stuck_val_r;
    assign match      = match_r;

endmodule

// File: tb/tb_bit_stream_monitor.sv
// Directed self-checking bench for bit_stream_monitor: default instance plus a
// CNT_W=4 instance sharing the same stimulus for the saturation scenario.
module tb_bit_stream_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, clear, in_valid, in_bit;
    logic [7:0] history, history4;
    logic [7:0] edge_count, run_len;
    logic [3:0] edge_count4, run_len4;
    logic       stuck, stuck_val, match, stuck4, stuck_val4, match4;

    int n_vec = 0;
    int n_err = 0;

    bit_stream_monitor dut (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .clear(clear),
        .history(history), .edge_count(edge_count), .run_len(run_len),
        .stuck(stuck), .stuck_val(stuck_val), .match(match)
    );

    bit_stream_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .clear(clear),
        .history(history4), .edge_count(edge_count4), .run_len(run_len4),
        .stuck(stuck4), .stuck_val(stuck_val4), .match(match4)
    );

    // stuck_val only carries meaning while stuck is high, so it is masked otherwise
    logic [26:0] obs;
    logic [18:0] obs4;
    assign obs  = {history, edge_count, run_len, stuck, stuck & stuck_val, match};
    assign obs4 = {history4, edge_count4, run_len4, stuck4, stuck4 & stuck_val4, match4};

    function automatic logic [26:0] pk(input logic [7:0] h, input logic [7:0] e,
                                       input logic [7:0] r, input logic s,
                                       input logic sv, input logic m);
        return {h, e, r, s, sv, m};
    endfunction

    function automatic logic [18:0] pk4(input logic [7:0] h, input logic [3:0] e,
                                        input logic [3:0] r, input logic s,
                                        input logic sv, input logic m);
        return {h, e, r, s, sv, m};
    endfunction

    task automatic send(input logic b);
        @(negedge clk);
        rst = 1'b0; clear = 1'b0; in_valid = 1'b1; in_bit = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic v, input logic b);
        @(negedge clk);
        rst = 1'b1; clear = 1'b0; in_valid = v; in_bit = b;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b1, 1'b1);
        do_reset(1'b1, 1'b1);
        n_vec++;
        if (obs !== 27'd0) begin
            n_err++; $display("FAIL reset: got %h want %h", obs, 27'd0);
        end
        n_vec++;
        if (obs4 !== 19'd0) begin
            n_err++; $display("FAIL reset4: got %h want %h", obs4, 19'd0);
        end
    endtask

    // Shared table for the 1,0,1,1,0,1,1 stream
    logic       pb[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] ph[7]  = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2D, 8'h5B};
    logic [7:0] pe[7]  = '{8'd0, 8'd1, 8'd2, 8'd2, 8'd3, 8'd4, 8'd4};
    logic [7:0] pr[7]  = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd1, 8'd1, 8'd2};
    logic       pm[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    task automatic test_pattern();
        logic [26:0] exp;
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            send(pb[i]);
            exp = pk(ph[i], pe[i], pr[i], 1'b0, 1'b0, pm[i]);
            n_vec++;
            if (obs !== exp) begin
                n_err++; $display("FAIL pattern bit%0d: got %h want %h", i, obs, exp);
            end
        end
        idle();
        exp = pk(8'h5B, 8'd4, 8'd2, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs !== exp) begin
            n_err++; $display("FAIL pattern hold: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_stuck();
        logic [26:0] exp;
        do_reset(1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            send(1'b0);
            exp = pk(8'h00, 8'd0, 8'(i), (i >= 6), 1'b0, 1'b0);
            n_vec++;
            if (obs !== exp) begin
                n_err++; $display("FAIL stuck zero%0d: got %h want %h", i, obs, exp);
            end
        end
        send(1'b1);
        exp = pk(8'h01, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs !== exp) begin
            n_err++; $display("FAIL stuck release: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_gaps();
        logic [26:0] exp;
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            send(pb[i]);
            exp = pk(ph[i], pe[i], pr[i], 1'b0, 1'b0, pm[i]);
            n_vec++;
            if (obs !== exp) begin
                n_err++; $display("FAIL gaps bit%0d: got %h want %h", i, obs, exp);
            end
            for (int g = 0; g < 3; g++) begin
                idle();
                exp = pk(ph[i], pe[i], pr[i], 1'b0, 1'b0, 1'b0);
                n_vec++;
                if (obs !== exp) begin
                    n_err++; $display("FAIL gaps hold%0d.%0d: got %h want %h", i, g, obs, exp);
                end
            end
        end
    endtask

    task automatic test_clear();
        logic [26:0] exp;
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) send(((i % 2) == 0) ? 1'b1 : 1'b0);
        exp = pk(8'h2A, 8'd5, 8'd1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs !== exp) begin
            n_err++; $display("FAIL clear pre: got %h want %h", obs, exp);
        end
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0; in_valid = 1'b0;
        n_vec++;
        if (obs !== 27'd0) begin
            n_err++; $display("FAIL clear zero: got %h want %h", obs, 27'd0);
        end
        send(1'b1);
        exp = pk(8'h01, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs !== exp) begin
            n_err++; $display("FAIL clear first: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_saturate();
        logic [18:0] exp4;
        logic [26:0] exp;
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            send(((i % 2) == 0) ? 1'b0 : 1'b1);
            if (i == 15) begin
                exp4 = pk4(8'h55, 4'd15, 4'd1, 1'b0, 1'b0, 1'b0);
                n_vec++;
                if (obs4 !== exp4) begin
                    n_err++; $display("FAIL sat4 bit16: got %h want %h", obs4, exp4);
                end
            end
        end
        exp4 = pk4(8'h55, 4'd15, 4'd1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs4 !== exp4) begin
            n_err++; $display("FAIL sat4 final: got %h want %h", obs4, exp4);
        end
        exp = pk(8'h55, 8'd19, 8'd1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs !== exp) begin
            n_err++; $display("FAIL sat8 final: got %h want %h", obs, exp);
        end
    endtask

    logic       rb[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] rh[7] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0E, 8'h1D, 8'h3B};
    logic [7:0] re[7] = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd3};
    logic [7:0] rr[7] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd1, 8'd1, 8'd2};
    logic       rm[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic test_reset_midstream();
        logic [26:0] exp;
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) send(1'b1);
        exp = pk(8'h3F, 8'd0, 8'd6, 1'b1, 1'b1, 1'b0);
        n_vec++;
        if (obs !== exp) begin
            n_err++; $display("FAIL mid stuck1: got %h want %h", obs, exp);
        end
        do_reset(1'b1, 1'b1);
        n_vec++;
        if (obs !== 27'd0) begin
            n_err++; $display("FAIL mid reset stuck: got %h want %h", obs, 27'd0);
        end
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        exp = pk(8'h0B, 8'd2, 8'd2, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (obs !== exp) begin
            n_err++; $display("FAIL mid pre: got %h want %h", obs, exp);
        end
        do_reset(1'b0, 1'b0);
        n_vec++;
        if (obs !== 27'd0) begin
            n_err++; $display("FAIL mid reset hist: got %h want %h", obs, 27'd0);
        end
        for (int i = 0; i < 7; i++) begin
            send(rb[i]);
            exp = pk(rh[i], re[i], rr[i], 1'b0, 1'b0, rm[i]);
            n_vec++;
            if (obs !== exp) begin
                n_err++; $display("FAIL mid post bit%0d: got %h want %h", i, obs, exp);
            end
        end
        idle();
        n_vec++;
        if (match !== 1'b0) begin
            n_err++; $display("FAIL mid pulse width: got %b want %b", match, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        test_reset();
        test_pattern();
        test_stuck();
        test_gaps();
        test_clear();
        test_saturate();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
